// File: rtl/axil_slv_regs_pkg.sv
// Shared definitions for the AXI4-Lite register slice feeding the LED/adder stage:
// response codes, register word indices, FSM state types and the byte-strobe merge.
package axil_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word indices (byte address bits [3:2])
    localparam logic [1:0] OFF_REG0    = 2'd0;
    localparam logic [1:0] OFF_REG1    = 2'd1;
    localparam logic [1:0] OFF_REG2    = 2'd2;
    localparam logic [1:0] OFF_SCRATCH = 2'd3;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Replace only the bytes whose strobe bit is set
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/axil_slv_regs_if.sv
// AXI4-Lite channel bundle between the PS/interconnect master and the register slave.
interface axil_slv_regs_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   s_awaddr;
    logic                s_awvalid;
    logic                s_awready;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_wvalid;
    logic                s_wready;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;
    logic [ADDR_W-1:0]   s_araddr;
    logic                s_arvalid;
    logic                s_arready;
    logic [DATA_W-1:0]   s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rvalid;
    logic                s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
               s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
               s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil_slv_regs.sv
// AXI4-Lite slave register bank: slv_reg1/slv_reg2 drive the adder stage, slv_reg0
// (its sum) is read back, plus one scratch register. Independent write and read FSMs.
module axil_slv_regs
    import axil_regs_pkg::*;
#(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 32,
    parameter logic [31:0] SCRATCH_RV = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    axil_slv_regs_if.slave    s,
    input  logic [DATA_W-1:0] slv_reg0,
    output logic [DATA_W-1:0] slv_reg1,
    output logic [DATA_W-1:0] slv_reg2
);

    // Byte-offset bits [1:0] are ignored by the register map
    logic [2*ADDR_W-1:0] unused_addr_bits;
    assign unused_addr_bits = {s.s_awaddr, s.s_araddr};

    logic [DATA_W-1:0] scratch;

    // ---------------- write path ----------------
    wr_state_t   wr_state, wr_state_n;
    logic        aw_done, aw_done_n, w_done, w_done_n;
    logic [1:0]  aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awready_n, wready_n, bvalid_n;
    logic [1:0]  bresp_n;
    logic        aw_hs, w_hs, have_aw, have_w, commit;
    logic [1:0]  commit_idx;
    logic [31:0] commit_data;
    logic [3:0]  commit_strb;

    assign aw_hs   = s.s_awready & s.s_awvalid;
    assign w_hs    = s.s_wready & s.s_wvalid;
    assign have_aw = aw_done | aw_hs;
    assign have_w  = w_done | w_hs;

    // A beat completing in the same cycle as the other side commits straight from the bus,
    // so bvalid rises one cycle after the last handshake.
    assign commit_idx  = aw_done ? aw_idx_q : s.s_awaddr[3:2];
    assign commit_data = w_done  ? wdata_q  : s.s_wdata;
    assign commit_strb = w_done  ? wstrb_q  : s.s_wstrb;

    // Write FSM next state and registered handshake outputs
    always_comb begin
        wr_state_n = wr_state;
        aw_done_n  = aw_done;
        w_done_n   = w_done;
        awready_n  = 1'b0;
        wready_n   = 1'b0;
        bvalid_n   = s.s_bvalid;
        bresp_n    = s.s_bresp;
        commit     = 1'b0;
        unique case (wr_state)
            W_IDLE: begin
                if (have_aw && have_w) begin
                    commit     = 1'b1;
                    wr_state_n = W_RESP;
                    aw_done_n  = 1'b0;
                    w_done_n   = 1'b0;
                    bvalid_n   = 1'b1;
                    bresp_n    = (commit_idx == OFF_REG0) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    aw_done_n = have_aw;
                    w_done_n  = have_w;
                    awready_n = ~have_aw;
                    wready_n  = ~have_w;
                end
            end
            W_RESP: begin
                if (s.s_bvalid && s.s_bready) begin
                    wr_state_n = W_IDLE;
                    bvalid_n   = 1'b0;
                    awready_n  = 1'b1;
                    wready_n   = 1'b1;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    // Write FSM state and handshake registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_state    <= W_IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            s.s_awready <= 1'b0;
            s.s_wready  <= 1'b0;
            s.s_bvalid  <= 1'b0;
            s.s_bresp   <= RESP_OKAY;
        end else begin
            wr_state    <= wr_state_n;
            aw_done     <= aw_done_n;
            w_done      <= w_done_n;
            s.s_awready <= awready_n;
            s.s_wready  <= wready_n;
            s.s_bvalid  <= bvalid_n;
            s.s_bresp   <= bresp_n;
        end
    end

    // Hold whichever beat arrives first until its partner shows up
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_hs) aw_idx_q <= s.s_awaddr[3:2];
            if (w_hs) begin
                wdata_q <= s.s_wdata;
                wstrb_q <= s.s_wstrb;
            end
        end
    end

    // Register bank update on commit; slv_reg0 is read-only and never stored
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slv_reg1 <= '0;
            slv_reg2 <= '0;
            scratch  <= SCRATCH_RV;
        end else if (commit) begin
            unique case (commit_idx)
                OFF_REG1:    slv_reg1 <= strb_merge(slv_reg1, commit_data, commit_strb);
                OFF_REG2:    slv_reg2 <= strb_merge(slv_reg2, commit_data, commit_strb);
                OFF_SCRATCH: scratch  <= strb_merge(scratch, commit_data, commit_strb);
                default:     ;
            endcase
        end
    end

    // ---------------- read path ----------------
    rd_state_t   rd_state, rd_state_n;
    logic        arready_n, rvalid_n, ar_hs;
    logic [31:0] rdata_n, rd_mux;

    assign ar_hs    = s.s_arready & s.s_arvalid;
    assign s.s_rresp = RESP_OKAY;

    // Read data source selected by word index
    always_comb begin
        rd_mux = '0;
        unique case (s.s_araddr[3:2])
            OFF_REG0:    rd_mux = slv_reg0;
            OFF_REG1:    rd_mux = slv_reg1;
            OFF_REG2:    rd_mux = slv_reg2;
            OFF_SCRATCH: rd_mux = scratch;
            default:     rd_mux = '0;
        endcase
    end

    // Read FSM next state and registered outputs
    always_comb begin
        rd_state_n = rd_state;
        arready_n  = 1'b0;
        rvalid_n   = s.s_rvalid;
        rdata_n    = s.s_rdata;
        unique case (rd_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_n = R_DATA;
                    rvalid_n   = 1'b1;
                    rdata_n    = rd_mux;
                end else begin
                    arready_n = 1'b1;
                end
            end
            R_DATA: begin
                if (s.s_rvalid && s.s_rready) begin
                    rd_state_n = R_IDLE;
                    rvalid_n   = 1'b0;
                    arready_n  = 1'b1;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    // Read FSM state and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_state    <= R_IDLE;
            s.s_arready <= 1'b0;
            s.s_rvalid  <= 1'b0;
            s.s_rdata   <= '0;
        end else begin
            rd_state    <= rd_state_n;
            s.s_arready <= arready_n;
            s.s_rvalid  <= rvalid_n;
            s.s_rdata   <= rdata_n;
        end
    end

endmodule

// File: tb/tb_axil_slv_regs.sv
// Scoreboard bench for axil_slv_regs: expected responses queued when a transaction is
// issued, compared when the matching B/R handshake appears on the bus.
module tb_axil_slv_regs;
    import axil_regs_pkg::*;

    localparam logic [31:0] SCR_RV = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] slv_reg0, slv_reg1, slv_reg2;

    axil_slv_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    axil_slv_regs #(.ADDR_W(4), .DATA_W(32), .SCRATCH_RV(SCR_RV)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .s        (bus.slave),
        .slv_reg0 (slv_reg0),
        .slv_reg1 (slv_reg1),
        .slv_reg2 (slv_reg2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t wr_q[$];
    exp_t rd_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_reg1, m_reg2, m_scr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    // Response monitor: a handshake is committed at the next rising edge
    exp_t mon_e;
    always @(negedge CLK) begin
        if (!RST && bus.s_bvalid && bus.s_bready) begin
            if (wr_q.size() == 0) check_eq("b_unexpected", 32'd1, 32'd0);
            else begin
                mon_e = wr_q.pop_front();
                check_eq({mon_e.tag, "_bresp"}, 32'(bus.s_bresp), 32'(mon_e.resp));
            end
        end
        if (!RST && bus.s_rvalid && bus.s_rready) begin
            if (rd_q.size() == 0) check_eq("r_unexpected", 32'd1, 32'd0);
            else begin
                mon_e = rd_q.pop_front();
                check_eq({mon_e.tag, "_rdata"}, bus.s_rdata, mon_e.data);
                check_eq({mon_e.tag, "_rresp"}, 32'(bus.s_rresp), 32'(mon_e.resp));
            end
        end
    end

    task automatic axil_write(input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int aw_delay, input int w_delay,
                              input string tag);
        exp_t e;
        e.tag  = tag;
        e.data = '0;
        e.resp = (addr[3:2] == 2'd0) ? 2'b10 : 2'b00;
        wr_q.push_back(e);
        case (addr[3:2])
            2'd1: m_reg1 = merge(m_reg1, data, strb);
            2'd2: m_reg2 = merge(m_reg2, data, strb);
            2'd3: m_scr  = merge(m_scr, data, strb);
            default: ;
        endcase
        fork
            begin
                int   g;
                logic ok;
                g = 0;
                if (aw_delay > 0) begin repeat (aw_delay) @(posedge CLK); #1; end
                bus.s_awaddr  = addr;
                bus.s_awvalid = 1'b1;
                do begin ok = bus.s_awready; @(posedge CLK); #1; g++; end while (!ok && g < 20);
                bus.s_awvalid = 1'b0;
                if (!ok) check_eq({tag, "_aw_timeout"}, 32'd0, 32'd1);
            end
            begin
                int   g;
                logic ok;
                g = 0;
                if (w_delay > 0) begin repeat (w_delay) @(posedge CLK); #1; end
                bus.s_wdata  = data;
                bus.s_wstrb  = strb;
                bus.s_wvalid = 1'b1;
                do begin ok = bus.s_wready; @(posedge CLK); #1; g++; end while (!ok && g < 20);
                bus.s_wvalid = 1'b0;
                if (!ok) check_eq({tag, "_w_timeout"}, 32'd0, 32'd1);
            end
        join
    endtask

    task automatic axil_read(input logic [3:0] addr, input logic [31:0] exp_data, input string tag);
        exp_t e;
        int   g;
        logic ok;
        e.tag  = tag;
        e.data = exp_data;
        e.resp = 2'b00;
        rd_q.push_back(e);
        g = 0;
        bus.s_araddr  = addr;
        bus.s_arvalid = 1'b1;
        do begin ok = bus.s_arready; @(posedge CLK); #1; g++; end while (!ok && g < 20);
        bus.s_arvalid = 1'b0;
        if (!ok) check_eq({tag, "_ar_timeout"}, 32'd0, 32'd1);
        check_eq({tag, "_rvalid_lat1"}, 32'(bus.s_rvalid), 32'd1);
    endtask

    task automatic b_accept(input int hold, input string tag);
        int         g;
        logic [1:0] resp0;
        g = 0;
        while (!bus.s_bvalid && g < 20) begin @(posedge CLK); #1; g++; end
        check_eq({tag, "_bvalid"}, 32'(bus.s_bvalid), 32'd1);
        resp0 = bus.s_bresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            check_eq({tag, "_bvalid_hold"}, 32'(bus.s_bvalid), 32'd1);
            check_eq({tag, "_bresp_hold"}, 32'(bus.s_bresp), 32'(resp0));
            check_eq({tag, "_awready_hold"}, 32'(bus.s_awready), 32'd0);
            check_eq({tag, "_wready_hold"}, 32'(bus.s_wready), 32'd0);
        end
        bus.s_bready = 1'b1;
        @(posedge CLK); #1;
        bus.s_bready = 1'b0;
        check_eq({tag, "_bvalid_drop"}, 32'(bus.s_bvalid), 32'd0);
        check_eq({tag, "_awready_back"}, 32'(bus.s_awready), 32'd1);
    endtask

    task automatic r_accept(input int hold, input string tag);
        logic [31:0] d0;
        d0 = bus.s_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            check_eq({tag, "_rvalid_hold"}, 32'(bus.s_rvalid), 32'd1);
            check_eq({tag, "_rdata_hold"}, bus.s_rdata, d0);
            check_eq({tag, "_arready_hold"}, 32'(bus.s_arready), 32'd0);
        end
        bus.s_rready = 1'b1;
        @(posedge CLK); #1;
        bus.s_rready = 1'b0;
        check_eq({tag, "_rvalid_drop"}, 32'(bus.s_rvalid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_awready"}, 32'(bus.s_awready), 32'd0);
        check_eq({tag, "_wready"},  32'(bus.s_wready),  32'd0);
        check_eq({tag, "_arready"}, 32'(bus.s_arready), 32'd0);
        check_eq({tag, "_bvalid"},  32'(bus.s_bvalid),  32'd0);
        check_eq({tag, "_rvalid"},  32'(bus.s_rvalid),  32'd0);
        check_eq({tag, "_bresp"},   32'(bus.s_bresp),   32'd0);
        check_eq({tag, "_rdata"},   bus.s_rdata,        32'd0);
        check_eq({tag, "_reg1"},    slv_reg1,           32'd0);
        check_eq({tag, "_reg2"},    slv_reg2,           32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
        bus.s_wdata  = '0; bus.s_wstrb   = '0; bus.s_wvalid = 1'b0;
        bus.s_bready = 1'b0;
        bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
        slv_reg0 = 32'hCAFE_0000;
        m_reg1 = '0; m_reg2 = '0; m_scr = SCR_RV;

        // 1: reset state, readies after release, mid-idle reset
        @(posedge CLK); #1;
        check_all_zero("t1_rst");
        RST = 1'b0;
        check_eq("t1_awready_pre", 32'(bus.s_awready), 32'd0);
        @(posedge CLK); #1;
        check_eq("t1_awready", 32'(bus.s_awready), 32'd1);
        check_eq("t1_wready",  32'(bus.s_wready),  32'd1);
        check_eq("t1_arready", 32'(bus.s_arready), 32'd1);
        axil_read(4'hC, SCR_RV, "t1_scratch_rv");
        r_accept(0, "t1_scratch_rv");
        RST = 1'b1;
        #1;
        check_all_zero("t1_midrst");
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        check_eq("t1_arready_rel", 32'(bus.s_arready), 32'd1);

        // 2: AW then W two cycles later
        axil_write(4'h4, 32'h0000_0001, 4'hF, 0, 2, "t2_wr");
        check_eq("t2_bvalid_lat", 32'(bus.s_bvalid), 32'd1);
        check_eq("t2_reg1", slv_reg1, m_reg1);
        check_eq("t2_reg1_const", slv_reg1, 32'h0000_0001);
        b_accept(0, "t2_wr");

        // 3: W first, partial strobes, read back
        axil_write(4'h8, 32'hDEAD_BEEF, 4'b0101, 2, 0, "t3_wr");
        check_eq("t3_reg2", slv_reg2, 32'h00AD_00EF);
        b_accept(0, "t3_wr");
        axil_read(4'h8, 32'h00AD_00EF, "t3_rd");
        r_accept(0, "t3_rd");

        // 4: write to read-only reg0, then read it from the downstream sum
        axil_write(4'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, "t4_wr");
        check_eq("t4_reg1", slv_reg1, m_reg1);
        check_eq("t4_reg2", slv_reg2, m_reg2);
        b_accept(0, "t4_wr");
        slv_reg0 = 32'h0000_1234;
        axil_read(4'h0, 32'h0000_1234, "t4_rd");
        r_accept(0, "t4_rd");

        // 5: back-pressure on both response channels
        axil_write(4'hC, 32'h1357_9BDF, 4'hF, 0, 0, "t5_wr");
        b_accept(5, "t5_wr");
        axil_read(4'hC, m_scr, "t5_rd");
        r_accept(5, "t5_rd");

        // zero strobes, upper-byte strobes, unaligned address bits
        axil_write(4'h4, 32'hFFFF_FFFF, 4'h0, 0, 0, "t5_nostrb");
        check_eq("t5_nostrb_reg1", slv_reg1, m_reg1);
        b_accept(0, "t5_nostrb");
        axil_write(4'h7, 32'hAABB_CCDD, 4'b1010, 1, 0, "t5_strb_hi");
        check_eq("t5_strb_hi_reg1", slv_reg1, m_reg1);
        b_accept(0, "t5_strb_hi");

        // read and write of scratch in the same commit cycle returns the old value
        fork
            axil_read(4'hC, m_scr, "t5_rw_old");
            axil_write(4'hC, 32'h0F0F_F0F0, 4'hF, 0, 0, "t5_rw_wr");
        join
        b_accept(0, "t5_rw_wr");
        r_accept(0, "t5_rw_old");
        axil_read(4'hC, m_scr, "t5_rw_new");
        r_accept(0, "t5_rw_new");
        axil_read(4'h4, m_reg1, "t5_rd_reg1");
        r_accept(0, "t5_rd_reg1");

        // 6: reset while a write response is pending
        axil_write(4'h4, 32'h0000_0055, 4'hF, 0, 0, "t6_wr");
        check_eq("t6_bvalid_pend", 32'(bus.s_bvalid), 32'd1);
        RST = 1'b1;
        #1;
        check_eq("t6_bvalid_rst", 32'(bus.s_bvalid), 32'd0);
        check_eq("t6_reg1_rst", slv_reg1, 32'd0);
        wr_q.delete();
        m_reg1 = '0; m_reg2 = '0; m_scr = SCR_RV;
        @(posedge CLK); #1;
        RST = 1'b0;
        bus.s_bready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check_eq("t6_no_bvalid", 32'(bus.s_bvalid), 32'd0);
            check_eq("t6_no_rvalid", 32'(bus.s_rvalid), 32'd0);
        end
        bus.s_bready = 1'b0;
        check_eq("t6_reg1_after", slv_reg1, 32'd0);
        axil_read(4'hC, SCR_RV, "t6_scratch");
        r_accept(0, "t6_scratch");

        check_eq("sb_wr_empty", 32'(wr_q.size()), 32'd0);
        check_eq("sb_rd_empty", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
